// File: rtl/fir_pkg.sv
// Shared widths and saturation limits for the fir40 downstream path.
// Default-width constants; the top re-derives limits for its own OUT_W.
package fir_pkg;

  localparam int IN_W_DEF  = 32;
  localparam int OUT_W_DEF = 16;

  localparam logic [OUT_W_DEF-1:0] SAT_MAX = {1'b0, {(OUT_W_DEF-1){1'b1}}};
  localparam logic [OUT_W_DEF-1:0] SAT_MIN = {1'b1, {(OUT_W_DEF-1){1'b0}}};

endpackage

// File: rtl/fir_sfifo.sv
// Synchronous FIFO with registered head; a write lands at the head one cycle later.
// Push at full is accepted only when the head pops in the same cycle.
module fir_sfifo
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_dat,
  input  logic                     i_rdy,
  output logic                     o_vld,
  output logic [DATA_W-1:0]        o_dat,
  output logic                     o_push_ok,
  output logic [$clog2(DEPTH):0]   o_fill
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_out_dat;
  logic              r_out_vld;

  logic [AW:0] w_count;
  logic [AW:0] w_rd_nxt;
  logic [AW:0] w_left;
  logic        w_full;
  logic        w_pop;
  logic        w_push;

  assign w_count  = r_wr_ptr - r_rd_ptr;
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop    = r_out_vld && i_rdy;
  assign w_push   = i_push && (!w_full || w_pop);
  assign w_rd_nxt = r_rd_ptr + {{AW{1'b0}}, w_pop};
  // Entries that remain after this cycle's pop, excluding this cycle's write.
  assign w_left   = w_count - {{AW{1'b0}}, w_pop};

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      r_rd_ptr  <= w_rd_nxt;
      r_out_vld <= (w_left != '0);
      // Head register holds its last value while the FIFO is empty.
      if (w_left != '0) begin
        r_out_dat <= r_mem[w_rd_nxt[AW-1:0]];
      end
    end
  end

  assign o_vld     = r_out_vld;
  assign o_dat     = r_out_dat;
  assign o_push_ok = w_push;
  assign o_fill    = w_count;

endmodule

// File: rtl/fir_decim_fifo.sv
// Decimates the fir40 output stream, rounds/scales/saturates kept samples and buffers them.
// Kept sample reaches out_data two edges after capture; drops are counted when the FIFO is full.
module fir_decim_fifo
  import fir_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int SHIFT = 8,
  parameter int DECIM = 4,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [IN_W-1:0]        in_data,
  input  logic                   in_valid,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   sat_flag,
  output logic [CNT_W-1:0]       drop_cnt,
  input  logic                   clr_stats
);

  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);

  localparam logic signed [IN_W:0] LIM_MAX =
    $signed({{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [IN_W:0] LIM_MIN =
    $signed({{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}});
  localparam logic signed [IN_W:0] RND = $signed((IN_W+1)'(1) << (SHIFT - 1));
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic [PH_W-1:0]  r_phase;
  logic             r_s1_vld;
  logic [OUT_W-1:0] r_s1_dat;
  logic             r_s1_sat;
  logic             r_sat_flag;
  logic [CNT_W-1:0] r_drop_cnt;

  logic               w_keep;
  logic signed [IN_W:0] w_t;
  logic signed [IN_W:0] w_r;
  logic [OUT_W-1:0]   w_sat_dat;
  logic               w_sat;
  logic               w_push_ok;
  logic               w_wr_sat;
  logic               w_drop;

  assign w_keep = in_valid && (r_phase == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
    end else if (in_valid) begin
      r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
    end
  end

  // One extra bit keeps the rounding add from overflowing; the shift floors,
  // so together they round half toward +inf.
  always_comb begin
    w_t       = $signed({in_data[IN_W-1], in_data}) + RND;
    w_r       = w_t >>> SHIFT;
    w_sat     = 1'b0;
    w_sat_dat = w_r[OUT_W-1:0];
    if (w_r > LIM_MAX) begin
      w_sat     = 1'b1;
      w_sat_dat = OUT_MAX;
    end else if (w_r < LIM_MIN) begin
      w_sat     = 1'b1;
      w_sat_dat = OUT_MIN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_dat <= '0;
      r_s1_sat <= 1'b0;
    end else begin
      r_s1_vld <= w_keep;
      if (w_keep) begin
        r_s1_dat <= w_sat_dat;
        r_s1_sat <= w_sat;
      end
    end
  end

  fir_sfifo #(
    .DATA_W (OUT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (r_s1_vld),
    .i_dat     (r_s1_dat),
    .i_rdy     (out_ready),
    .o_vld     (out_valid),
    .o_dat     (out_data),
    .o_push_ok (w_push_ok),
    .o_fill    (fill)
  );

  assign w_wr_sat = w_push_ok && r_s1_sat;
  assign w_drop   = r_s1_vld && !w_push_ok;

  // A new event in the same cycle as a clear takes priority over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_flag <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_wr_sat) begin
        r_sat_flag <= 1'b1;
      end else if (clr_stats) begin
        r_sat_flag <= 1'b0;
      end
      if (w_drop) begin
        if (clr_stats) begin
          r_drop_cnt <= CNT_W'(1);
        end else if (r_drop_cnt != {CNT_W{1'b1}}) begin
          r_drop_cnt <= r_drop_cnt + 1'b1;
        end
      end else if (clr_stats) begin
        r_drop_cnt <= '0;
      end
    end
  end

  assign sat_flag = r_sat_flag;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Bench for fir_decim_fifo: one instance with DECIM=1, one with DECIM=4, sharing clock and reset.
// Outputs are checked against a per-instance expected queue filled as stimulus is driven.
module tb_fir_decim_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] in_data1, in_data4;
  logic        in_valid1, in_valid4;
  logic [15:0] out_data1, out_data4;
  logic        out_valid1, out_valid4;
  logic        out_ready1, out_ready4;
  logic [4:0]  fill1, fill4;
  logic        sat1, sat4;
  logic [15:0] drop1, drop4;
  logic        clr1, clr4;

  fir_decim_fifo #(.DECIM(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .fill(fill1), .sat_flag(sat1), .drop_cnt(drop1), .clr_stats(clr1)
  );

  fir_decim_fifo #(.DECIM(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_valid(in_valid4),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready4),
    .fill(fill4), .sat_flag(sat4), .drop_cnt(drop4), .clr_stats(clr4)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_out4 = 0;
  int ph4 = 0;
  logic [15:0] q1[$];
  logic [15:0] q4[$];

  typedef struct {
    logic [31:0] din;
    logic [15:0] dout;
    logic        sat;
  } vec_t;
  vec_t tv[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid1 && out_ready1) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL u1_extra_out: actual=%h required=no output", out_data1);
      end else begin
        chk("u1_data", 32'(out_data1), 32'(q1.pop_front()));
      end
    end
    if (rst_n && out_valid4 && out_ready4) begin
      n_out4++;
      if (q4.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL u4_extra_out: actual=%h required=no output", out_data4);
      end else begin
        chk("u4_data", 32'(out_data4), 32'(q4.pop_front()));
      end
    end
  end

  task automatic push1(input logic [31:0] d, input bit keep, input logic [15:0] e);
    @(posedge clk); #1;
    in_data1  = d;
    in_valid1 = 1'b1;
    if (keep) q1.push_back(e);
  endtask

  task automatic idle1();
    @(posedge clk); #1;
    in_valid1 = 1'b0;
  endtask

  task automatic push4(input logic [31:0] d, input logic [15:0] e);
    @(posedge clk); #1;
    in_data4  = d;
    in_valid4 = 1'b1;
    if (ph4 == 0) q4.push_back(e);
    ph4 = (ph4 + 1) % 4;
  endtask

  task automatic idle4();
    @(posedge clk); #1;
    in_valid4 = 1'b0;
  endtask

  task automatic drain(input int which, input int budget);
    int n = 0;
    while (((which == 1) ? q1.size() : q4.size()) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk($sformatf("drain_left_u%0d", which),
        32'((which == 1) ? q1.size() : q4.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    tv[0]  = '{32'h0000_0000, 16'h0000, 1'b0};
    tv[1]  = '{32'h0000_007F, 16'h0000, 1'b0};
    tv[2]  = '{32'h0000_0080, 16'h0001, 1'b0};
    tv[3]  = '{32'h0000_0180, 16'h0002, 1'b0};
    tv[4]  = '{32'h0000_017F, 16'h0001, 1'b0};
    tv[5]  = '{32'hFFFF_FE80, 16'hFFFF, 1'b0};
    tv[6]  = '{32'hFFFF_FE7F, 16'hFFFE, 1'b0};
    tv[7]  = '{32'h007F_FE80, 16'h7FFF, 1'b0};
    tv[8]  = '{32'hFF80_0000, 16'h8000, 1'b0};
    tv[9]  = '{32'h7FFF_FFFF, 16'h7FFF, 1'b1};
    tv[10] = '{32'h8000_0000, 16'h8000, 1'b1};
    tv[11] = '{32'hFF7F_FF7F, 16'h8000, 1'b1};

    in_data1 = '0; in_valid1 = 1'b0; out_ready1 = 1'b1; clr1 = 1'b0;
    in_data4 = '0; in_valid4 = 1'b0; out_ready4 = 1'b1; clr4 = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid1), 32'd0);
    chk("rst_out_data",  32'(out_data1),  32'd0);
    chk("rst_fill",      32'(fill1),      32'd0);
    chk("rst_sat_flag",  32'(sat1),       32'd0);
    chk("rst_drop_cnt",  32'(drop1),      32'd0);
    rst_n = 1'b1;

    // Rounding and saturation vectors, DECIM=1
    for (int i = 0; i < 12; i++) begin
      push1(tv[i].din, 1'b1, tv[i].dout);
      idle1();
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("sat_flag_v%0d", i), 32'(sat1), 32'(tv[i].sat));
    end
    drain(1, 20);
    @(posedge clk); #1 clr1 = 1'b1;
    @(posedge clk); #1 clr1 = 1'b0;
    chk("sat_flag_after_clr", 32'(sat1), 32'd0);

    // Decimation by 4 with continuous input and first-output latency
    n_out4 = 0;
    for (int i = 0; i < 12; i++) begin
      push4(32'((i + 1) * 256), 16'(i + 1));
      if (i == 2) chk("first_valid_early", 32'(out_valid4), 32'd0);
      if (i == 3) begin
        chk("first_valid_lat", 32'(out_valid4), 32'd1);
        chk("first_data",      32'(out_data4),  32'd1);
      end
    end
    idle4();
    drain(4, 20);
    chk("decim_count", 32'(n_out4), 32'd3);

    // Gapped input: in_valid every third cycle
    n_out4 = 0;
    for (int j = 1; j <= 8; j++) begin
      push4(32'((20 + j) * 256), 16'(20 + j));
      idle4();
      idle4();
    end
    drain(4, 20);
    chk("gap_count", 32'(n_out4), 32'd2);

    // Fill to full with drops, then push+pop at full
    out_ready1 = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      push1(32'(j * 256), (j <= 16), 16'(j));
    end
    idle1();
    repeat (3) @(posedge clk);
    #1;
    chk("full_fill", 32'(fill1), 32'd16);
    chk("full_drop", 32'(drop1), 32'd4);
    push1(32'(100 * 256), 1'b1, 16'd100);
    @(posedge clk); #1;
    in_valid1  = 1'b0;
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    chk("pushpop_fill", 32'(fill1), 32'd16);
    chk("pushpop_drop", 32'(drop1), 32'd4);
    out_ready1 = 1'b1;
    drain(1, 40);
    chk("fill_after_drain", 32'(fill1), 32'd0);
    @(posedge clk); #1 clr1 = 1'b1;
    @(posedge clk); #1 clr1 = 1'b0;
    chk("drop_after_clr", 32'(drop1), 32'd0);

    // Reset mid-stream: FIFO holding 7, u4 phase left at 2
    out_ready1 = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      push1(32'(j * 256), 1'b1, 16'(j));
    end
    idle1();
    push4(32'(200 * 256), 16'd200);
    push4(32'(201 * 256), 16'd201);
    idle4();
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_fill", 32'(fill1), 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid1), 32'd0);
    chk("async_rst_fill",  32'(fill1),      32'd0);
    q1.delete();
    q4.delete();
    ph4 = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    push4(32'(77 * 256), 16'd77);
    idle4();
    drain(4, 20);
    out_ready1 = 1'b1;
    push1(32'(5 * 256), 1'b1, 16'd5);
    idle1();
    drain(1, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
